// File: rtl/mmio_disp_pkg.sv
// rtl/mmio_disp_pkg.sv - shared constants and FSM state type for the MMIO display bank
package mmio_disp_pkg;

  // Register indices past the channel block, relative to NUM_CH
  localparam int IDX_STATUS_OFS = 0;
  localparam int IDX_CTRL_OFS   = 1;

  localparam int ST_COUNT_W   = 16;
  localparam int ST_OVF_BIT   = 16;
  localparam int ST_EMPTY_BIT = 17;
  localparam int ST_FULL_BIT  = 18;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/mmio_display_bank_if.sv
// rtl/mmio_display_bank_if.sv - memory-request/response bus between bridge and display bank
interface mmio_display_bank_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wmask;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/disp_log_fifo.sv
// rtl/disp_log_fifo.sv - synchronous write-log FIFO with flush, registered count and overflow pulse
module disp_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  // A pop on the same edge frees the head slot, so a full FIFO still accepts
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/mmio_display_bank.sv
// rtl/mmio_display_bank.sv - byte-maskable display registers with STATUS/CONTROL and a write log
module mmio_display_bank
  import mmio_disp_pkg::*;
#(
  parameter int              DATA_WIDTH = 64,
  parameter int              ADDR_WIDTH = 64,
  parameter int              NUM_CH     = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter longint unsigned BASE_ADDR  = 0,
  localparam int             CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  mmio_display_bank_if.slave           bus,
  output logic [NUM_CH*DATA_WIDTH-1:0] display_o,
  output logic                         log_valid,
  input  logic                         log_ready,
  output logic [CH_W-1:0]              log_ch,
  output logic [DATA_WIDTH-1:0]        log_data
);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFS_BITS = $clog2(NB);
  localparam int FAW      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } log_entry_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ch_q [NUM_CH];
  logic                  overflow_q;

  logic [ADDR_WIDTH-1:0] offset, idx;
  logic                  below, is_ch, is_status, is_ctrl, hit;
  logic [CH_W-1:0]       ch_sel;
  logic [DATA_WIDTH-1:0] cur_val, new_val, rd_val;
  logic [31:0]           status_word;
  logic                  accept, ch_we, ctrl_we, do_flush, do_clr, pop;
  logic [FAW:0]          fifo_count;
  logic                  fifo_full, fifo_empty, fifo_ovf;
  log_entry_t            push_entry, head_entry;

  assign below     = bus.req_addr < ADDR_WIDTH'(BASE_ADDR);
  assign offset    = bus.req_addr - ADDR_WIDTH'(BASE_ADDR);
  assign idx       = offset >> OFS_BITS;
  assign is_ch     = !below && (idx < ADDR_WIDTH'(NUM_CH));
  assign is_status = !below && (idx == ADDR_WIDTH'(NUM_CH + IDX_STATUS_OFS));
  assign is_ctrl   = !below && (idx == ADDR_WIDTH'(NUM_CH + IDX_CTRL_OFS));
  assign hit       = is_ch || is_status || is_ctrl;
  assign ch_sel    = idx[CH_W-1:0];
  assign cur_val   = is_ch ? ch_q[ch_sel] : '0;

  always_comb begin
    new_val = cur_val;
    for (int b = 0; b < NB; b++) begin
      if (bus.req_wmask[b]) new_val[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
    end
  end

  always_comb begin
    status_word                   = '0;
    status_word[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
    status_word[ST_OVF_BIT]       = overflow_q;
    status_word[ST_EMPTY_BIT]     = fifo_empty;
    status_word[ST_FULL_BIT]      = fifo_full;
  end

  // CONTROL is write-only, so it falls through to zero like an unmapped read
  assign rd_val = is_ch ? cur_val : (is_status ? DATA_WIDTH'(status_word) : '0);

  assign accept   = (state_q == S_IDLE) && bus.req_valid;
  assign ch_we    = accept && bus.req_we && is_ch;
  assign ctrl_we  = accept && bus.req_we && is_ctrl && bus.req_wmask[0];
  assign do_flush = ctrl_we && bus.req_wdata[CTRL_FLUSH_BIT];
  assign do_clr   = ctrl_we && bus.req_wdata[CTRL_CLR_OVF_BIT];
  assign pop      = log_valid && log_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else if (accept) begin
      bus.resp_rdata <= (bus.req_we || !hit) ? '0 : rd_val;
      bus.resp_err   <= !hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else if (ch_we) begin
      ch_q[ch_sel] <= new_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         overflow_q <= 1'b0;
    else if (do_clr)   overflow_q <= 1'b0;
    else if (fifo_ovf) overflow_q <= 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_disp
    assign display_o[k*DATA_WIDTH +: DATA_WIDTH] = ch_q[k];
  end

  assign push_entry = '{ch: ch_sel, data: new_val};

  disp_log_fifo #(
    .WIDTH ($bits(log_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ch_we),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (do_flush),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  assign log_valid = !fifo_empty;
  assign log_ch    = head_entry.ch;
  assign log_data  = head_entry.data;
endmodule

// File: tb/tb_mmio_display_bank.sv
// tb/tb_mmio_display_bank.sv - directed self-checking bench for mmio_display_bank
module tb_mmio_display_bank;
  localparam int          DW   = 64;
  localparam int          AW   = 64;
  localparam int          NCH  = 4;
  localparam int          FD   = 8;
  localparam logic [63:0] BASE = 64'h1000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mmio_display_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [NCH*DW-1:0] display_o;
  logic              log_valid;
  logic              log_ready;
  logic [1:0]        log_ch;
  logic [DW-1:0]     log_data;

  mmio_display_bank #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH),
    .FIFO_DEPTH (FD),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .display_o (display_o),
    .log_valid (log_valid),
    .log_ready (log_ready),
    .log_ch    (log_ch),
    .log_data  (log_data)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] rd;
  logic        er;

  function automatic logic [63:0] addr_of(input int idx);
    return BASE + 64'(idx) * 64'd8;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] data,
                      input logic [7:0] mask, input logic pop_too,
                      output logic [63:0] rdata, output logic err);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_wmask = mask;
    log_ready     = pop_too;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    log_ready     = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid_wait", bus.resp_valid, 1);
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic rd_chk(input int idx, input logic [63:0] exp, input string tag);
    logic [63:0] d;
    logic        e;
    xact(1'b0, addr_of(idx), 64'h0, 8'h00, 1'b0, d, e);
    chk(tag, d, exp);
    chk({tag, "_err"}, e, 0);
  endtask

  task automatic wr(input int idx, input logic [63:0] data, input logic [7:0] mask);
    logic [63:0] d;
    logic        e;
    xact(1'b1, addr_of(idx), data, mask, 1'b0, d, e);
  endtask

  task automatic drain(input logic [1:0] ch, input logic [63:0] data, input string tag);
    chk({tag, "_valid"}, log_valid, 1);
    chk({tag, "_ch"}, log_ch, ch);
    chk({tag, "_data"}, log_data, data);
    log_ready = 1'b1;
    @(posedge clk);
    #1;
    log_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b0;
    log_ready      = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_log_valid", log_valid, 0);
    chk("rst_display", display_o, 0);
    for (int i = 0; i < NCH + 2; i++)
      rd_chk(i, (i == NCH) ? 64'h20000 : 64'h0, $sformatf("rst_rd%0d", i));

    // Masked write of ch2 over an all-ones value
    wr(2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    drain(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, "log_ones");
    wr(2, 64'h1122_3344_5566_7788, 8'h0F);
    chk("mask_log_valid", log_valid, 1);
    chk("mask_log_ch", log_ch, 2);
    chk("mask_log_data", log_data, 64'hFFFF_FFFF_5566_7788);
    chk("mask_display", display_o[2*DW +: DW], 64'hFFFF_FFFF_5566_7788);
    rd_chk(2, 64'hFFFF_FFFF_5566_7788, "mask_rd_ch2");
    rd_chk(NCH, 64'h1, "mask_status");
    drain(2'd2, 64'hFFFF_FFFF_5566_7788, "mask_drain");
    rd_chk(NCH, 64'h20000, "mask_status_empty");

    // Nine writes into an eight-deep log with no draining
    for (int i = 1; i <= 9; i++) wr(0, 64'(i), 8'hFF);
    rd_chk(NCH, 64'h50008, "ovf_status");
    chk("ovf_display", display_o[0 +: DW], 64'd9);
    for (int i = 1; i <= 8; i++) drain(2'd0, 64'(i), $sformatf("ovf_drain%0d", i));
    rd_chk(NCH, 64'h30000, "ovf_after_drain");
    wr(NCH + 1, 64'h1, 8'h00);
    rd_chk(NCH, 64'h30000, "ctrl_nomask");
    wr(NCH + 1, 64'h1, 8'h01);
    rd_chk(NCH, 64'h20000, "ctrl_clear");

    // Push into a full log on the same edge as a pop
    for (int i = 0; i < 8; i++) wr(1, 64'h10 + 64'(i), 8'hFF);
    rd_chk(NCH, 64'h40008, "full_status");
    xact(1'b1, addr_of(1), 64'hAA, 8'hFF, 1'b1, rd, er);
    rd_chk(NCH, 64'h40008, "full_pop_status");
    for (int i = 1; i < 8; i++) drain(2'd1, 64'h10 + 64'(i), $sformatf("full_drain%0d", i));
    drain(2'd1, 64'hAA, "full_drain_last");
    rd_chk(NCH, 64'h20000, "full_empty");

    // Flush together with a pop
    wr(3, 64'h33, 8'hFF);
    wr(3, 64'h34, 8'hFF);
    xact(1'b1, addr_of(NCH + 1), 64'h2, 8'h01, 1'b1, rd, er);
    chk("flush_log_valid", log_valid, 0);
    rd_chk(NCH, 64'h20000, "flush_status");

    // Decode errors
    xact(1'b1, addr_of(NCH + 2), 64'hDEAD, 8'hFF, 1'b0, rd, er);
    chk("err_wr_err", er, 1);
    chk("err_wr_rdata", rd, 0);
    xact(1'b0, addr_of(NCH + 2), 64'h0, 8'h00, 1'b0, rd, er);
    chk("err_rd_err", er, 1);
    chk("err_rd_rdata", rd, 0);
    xact(1'b1, BASE - 64'd8, 64'hBEEF, 8'hFF, 1'b0, rd, er);
    chk("below_err", er, 1);
    chk("below_rdata", rd, 0);
    chk("err_display", display_o,
        {64'h34, 64'hFFFF_FFFF_5566_7788, 64'hAA, 64'h9});
    chk("err_log_valid", log_valid, 0);
    rd_chk(NCH, 64'h20000, "err_status");

    // Response held off by resp_ready for five cycles
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr_of(NCH + 3);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_resp_valid%0d", i), bus.resp_valid, 1);
      chk($sformatf("hold_req_ready%0d", i), bus.req_ready, 0);
    end
    chk("hold_err", bus.resp_err, 1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;

    // Reset while a response is pending with three log entries
    wr(0, 64'hA0, 8'hFF);
    wr(1, 64'hA1, 8'hFF);
    wr(2, 64'hA2, 8'hFF);
    rd_chk(NCH, 64'h3, "pre_rst_status");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr_of(0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_resp_valid", bus.resp_valid, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_log_valid", log_valid, 0);
    chk("mid_rst_display", display_o, 0);
    chk("mid_rst_rdata", bus.resp_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    rd_chk(NCH, 64'h20000, "post_rst_status");
    rd_chk(2, 64'h0, "post_rst_ch2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
